// File: rtl/wam_pkg.sv
// wam_pkg: shared constants, types and BCD digit helper for the whack-a-mole player side
package wam_pkg;

    localparam int          NHOLE     = 8;
    localparam logic [15:0] SCORE_MAX = 16'h9999;
    localparam logic [7:0]  COUNT_MAX = 8'hFF;

    typedef logic [3:0] bcd_t;

    typedef enum logic {IDLE, HIT} hole_st_t;

    // one BCD digit plus a small addend; returns {carry, digit}
    function automatic logic [4:0] bcd_add(input bcd_t a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 5'd9) ? {1'b1, 4'(s - 5'd10)} : s;
    endfunction

endpackage

// File: rtl/wam_hit_if.sv
// wam_hit_if: player-side bus between the game harness and the hit judge
interface wam_hit_if
    import wam_pkg::*;
();
    logic             run;
    logic [NHOLE-1:0] btn;
    logic [NHOLE-1:0] holes;
    logic [NHOLE-1:0] hit;
    logic [15:0]      score;
    logic [7:0]       miss;
    logic [7:0]       combo;
    logic             cout0;

    modport master (output run, btn, holes, input hit, score, miss, combo, cout0);
    modport slave  (input run, btn, holes, output hit, score, miss, combo, cout0);
endinterface

// File: rtl/wam_dbn.sv
// wam_dbn: two-flop synchroniser, debounce and registered rising-edge press pulse for one button
module wam_dbn #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DB_CYCLES);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d, prev_q, press_q;

    // accept a new level only after DB_CYCLES consecutive differing samples
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1))
                stable_d = sync_q[1];
            else
                cnt_d = cnt_q + CW'(1);
        end
    end

    // synchroniser, debounce state and one-cycle press on a stable rise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            press_q  <= stable_q & ~prev_q;
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/wam_hit.sv
// wam_hit: judges debounced presses against live moles, drives hit flags and keeps score/miss/combo
module wam_hit
    import wam_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int HIT_HOLD  = 8
) (
    input  logic     clk_19,
    input  logic     clr,
    wam_hit_if.slave bus
);
    localparam int HW = $clog2(HIT_HOLD);

    logic [NHOLE-1:0] press, new_hit, miss_v, hit_v;
    hole_st_t         st_q   [NHOLE];
    logic [HW-1:0]    hold_q [NHOLE];
    logic [3:0]       n;
    logic [4:0]       a0, a1, a2, a3;
    logic [15:0]      score_q, score_d;
    logic [7:0]       miss_q, miss_d, combo_q, combo_d;
    logic [8:0]       combo_sum;
    logic             cout0_q, cout0_d;

    for (genvar i = 0; i < NHOLE; i++) begin : g_dbn
        wam_dbn #(.DB_CYCLES(DB_CYCLES)) u_dbn (
            .clk_i  (clk_19),
            .rst_i  (clr),
            .btn_i  (bus.btn[i]),
            .press_o(press[i])
        );
    end

    // a press counts only on an idle hole while running; mole up is a hit, else a miss
    always_comb begin
        for (int k = 0; k < NHOLE; k++) begin
            new_hit[k] = press[k] & bus.run & (st_q[k] == IDLE) & bus.holes[k];
            miss_v[k]  = press[k] & bus.run & (st_q[k] == IDLE) & ~bus.holes[k];
            hit_v[k]   = st_q[k] == HIT;
        end
    end

    // per-hole FSMs: hold hit until the mole clears or the hold window expires
    always_ff @(posedge clk_19) begin
        for (int k = 0; k < NHOLE; k++) begin
            if (clr || !bus.run) begin
                st_q[k]   <= IDLE;
                hold_q[k] <= '0;
            end else if (st_q[k] == IDLE) begin
                if (new_hit[k]) begin
                    st_q[k]   <= HIT;
                    hold_q[k] <= HW'(HIT_HOLD - 1);
                end
            end else if (!bus.holes[k] || hold_q[k] == '0) begin
                st_q[k] <= IDLE;
            end else begin
                hold_q[k] <= hold_q[k] - 1'b1;
            end
        end
    end

    // BCD score add with rippled carries; a carry out of the top digit clamps to 9999
    always_comb begin
        n         = 4'($countones(new_hit));
        a0        = bcd_add(score_q[3:0], n);
        a1        = bcd_add(score_q[7:4], {3'b0, a0[4]});
        a2        = bcd_add(score_q[11:8], {3'b0, a1[4]});
        a3        = bcd_add(score_q[15:12], {3'b0, a2[4]});
        score_d   = a3[4] ? SCORE_MAX : {a3[3:0], a2[3:0], a1[3:0], a0[3:0]};
        cout0_d   = a0[4] & ~a3[4];
        miss_d    = (|miss_v && miss_q != COUNT_MAX) ? miss_q + 1'b1 : miss_q;
        combo_sum = {1'b0, combo_q} + {5'b0, n};
        combo_d   = |miss_v ? {4'b0, n} : (combo_sum[8] ? COUNT_MAX : combo_sum[7:0]);
    end

    // score, miss, combo and level-up pulse registers
    always_ff @(posedge clk_19) begin
        if (clr) begin
            score_q <= '0;
            miss_q  <= '0;
            combo_q <= '0;
            cout0_q <= 1'b0;
        end else begin
            score_q <= score_d;
            miss_q  <= miss_d;
            combo_q <= combo_d;
            cout0_q <= cout0_d;
        end
    end

    assign bus.hit   = hit_v;
    assign bus.score = score_q;
    assign bus.miss  = miss_q;
    assign bus.combo = combo_q;
    assign bus.cout0 = cout0_q;
endmodule
